// File: rtl/sdram_cmd_arbiter_pkg.sv
// Shared SDRAM command encodings ({CS,RAS,CAS,WE}) and arbiter state codes
// for the SDRAM command/address pin arbiter.
package sdram_cmd_arbiter_pkg;

  localparam logic [3:0] NOPC     = 4'b0111;
  localparam logic [3:0] PRECHAGE = 4'b0010;
  localparam logic [3:0] AUTOREF  = 4'b0001;
  localparam logic [3:0] ACTIVE   = 4'b0011;
  localparam logic [3:0] READ     = 4'b0101;
  localparam logic [3:0] WRITE    = 4'b0100;

  typedef enum logic [2:0] {
    SDARBINIT = 3'd0,
    SDARBIDLE = 3'd1,
    SDARBAREF = 3'd2,
    SDARBWR   = 3'd3,
    SDARBRD   = 3'd4
  } arb_state_e;

endpackage : sdram_cmd_arbiter_pkg

// File: rtl/sdram_cmd_arbiter.sv
// Owns the SDRAM command/address/bank pins and hands them to the init sequencer,
// the auto-refresh engine, or the write/read paths; pins are registered (1-cycle latency).
module sdram_cmd_arbiter
  import sdram_cmd_arbiter_pkg::*;
#(
  parameter int SDRAMLINE = 2048,
  parameter int ADDRW     = 13,
  parameter int BAW       = 2
) (
  input  logic                         Clk,
  input  logic                         Rest,
  input  logic                         InitDone,
  input  logic [3:0]                   InitCmd,
  input  logic [ADDRW-1:0]             InitAddr,
  input  logic [BAW-1:0]               InitBa,
  input  logic                         ArefReq,
  input  logic [3:0]                   ArefCmd,
  input  logic [$clog2(SDRAMLINE)-1:0] ArefMode,
  input  logic                         ArefDone,
  output logic                         ArefStart,
  input  logic                         WrReq,
  output logic                         WrGrant,
  input  logic [3:0]                   WrCmd,
  input  logic [ADDRW-1:0]             WrAddr,
  input  logic [BAW-1:0]               WrBa,
  input  logic                         WrDone,
  input  logic                         RdReq,
  output logic                         RdGrant,
  input  logic [3:0]                   RdCmd,
  input  logic [ADDRW-1:0]             RdAddr,
  input  logic [BAW-1:0]               RdBa,
  input  logic                         RdDone,
  output logic [3:0]                   SdramCmd,
  output logic [ADDRW-1:0]             SdramAddr,
  output logic [BAW-1:0]               SdramBa,
  output logic                         ArefMiss
);

  arb_state_e       state_q, state_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [BAW-1:0]   ba_q, ba_d;
  logic             wr_grant_q, wr_grant_d;
  logic             rd_grant_q, rd_grant_d;
  logic             aref_start_q, aref_start_d;
  logic             aref_miss_q, aref_miss_d;
  logic             last_rd_q, last_rd_d;

  // Next-state, pin mux selection and handshake outputs.
  always_comb begin
    state_d      = state_q;
    cmd_d        = NOPC;
    addr_d       = {ADDRW{1'b0}};
    ba_d         = {BAW{1'b0}};
    aref_start_d = 1'b0;
    last_rd_d    = last_rd_q;

    case (state_q)
      SDARBINIT: begin
        cmd_d  = InitCmd;
        addr_d = InitAddr;
        ba_d   = InitBa;
        if (InitDone) begin
          state_d = SDARBIDLE;
        end else begin
          state_d = SDARBINIT;
        end
      end
      SDARBIDLE: begin
        // Refresh outranks data traffic; with both data requests pending the
        // path opposite the last served one wins.
        if (ArefReq) begin
          state_d      = SDARBAREF;
          aref_start_d = 1'b1;
        end else if (WrReq && RdReq) begin
          if (last_rd_q) begin
            state_d = SDARBWR;
          end else begin
            state_d = SDARBRD;
          end
        end else if (WrReq) begin
          state_d = SDARBWR;
        end else if (RdReq) begin
          state_d = SDARBRD;
        end else begin
          state_d = SDARBIDLE;
        end
      end
      SDARBAREF: begin
        cmd_d  = ArefCmd;
        addr_d = ADDRW'(ArefMode);
        if (ArefDone) begin
          state_d = SDARBIDLE;
        end else begin
          state_d = SDARBAREF;
        end
      end
      SDARBWR: begin
        cmd_d  = WrCmd;
        addr_d = WrAddr;
        ba_d   = WrBa;
        if (WrDone) begin
          state_d   = SDARBIDLE;
          last_rd_d = 1'b0;
        end else begin
          state_d = SDARBWR;
        end
      end
      SDARBRD: begin
        cmd_d  = RdCmd;
        addr_d = RdAddr;
        ba_d   = RdBa;
        if (RdDone) begin
          state_d   = SDARBIDLE;
          last_rd_d = 1'b1;
        end else begin
          state_d = SDARBRD;
        end
      end
      default: begin
        state_d = SDARBIDLE;
      end
    endcase

    wr_grant_d  = (state_d == SDARBWR);
    rd_grant_d  = (state_d == SDARBRD);
    // A refresh command seen outside AREF means the engine fired on its own.
    aref_miss_d = aref_miss_q | ((ArefCmd != NOPC) && (state_q != SDARBAREF));
  end

  // State and registered pad/handshake outputs.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      state_q      <= SDARBINIT;
      cmd_q        <= NOPC;
      addr_q       <= {ADDRW{1'b0}};
      ba_q         <= {BAW{1'b0}};
      wr_grant_q   <= 1'b0;
      rd_grant_q   <= 1'b0;
      aref_start_q <= 1'b0;
      aref_miss_q  <= 1'b0;
      last_rd_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      ba_q         <= ba_d;
      wr_grant_q   <= wr_grant_d;
      rd_grant_q   <= rd_grant_d;
      aref_start_q <= aref_start_d;
      aref_miss_q  <= aref_miss_d;
      last_rd_q    <= last_rd_d;
    end
  end

  assign SdramCmd  = cmd_q;
  assign SdramAddr = addr_q;
  assign SdramBa   = ba_q;
  assign WrGrant   = wr_grant_q;
  assign RdGrant   = rd_grant_q;
  assign ArefStart = aref_start_q;
  assign ArefMiss  = aref_miss_q;

endmodule : sdram_cmd_arbiter

// File: tb/tb_sdram_cmd_arbiter.sv
// Directed self-checking bench for sdram_cmd_arbiter: init hand-off, refresh
// handshake, write/read alternation, refresh behind a burst, ArefMiss, async reset.
module tb_sdram_cmd_arbiter;
  import sdram_cmd_arbiter_pkg::*;

  logic        Clk, Rest;
  logic        InitDone;
  logic [3:0]  InitCmd;
  logic [12:0] InitAddr;
  logic [1:0]  InitBa;
  logic        ArefReq;
  logic [3:0]  ArefCmd;
  logic [10:0] ArefMode;
  logic        ArefDone, ArefStart;
  logic        WrReq, WrGrant, WrDone;
  logic [3:0]  WrCmd;
  logic [12:0] WrAddr;
  logic [1:0]  WrBa;
  logic        RdReq, RdGrant, RdDone;
  logic [3:0]  RdCmd;
  logic [12:0] RdAddr;
  logic [1:0]  RdBa;
  logic [3:0]  SdramCmd;
  logic [12:0] SdramAddr;
  logic [1:0]  SdramBa;
  logic        ArefMiss;

  int n_cmp = 0;
  int n_err = 0;

  sdram_cmd_arbiter #(.SDRAMLINE(2048), .ADDRW(13), .BAW(2)) dut (
    .Clk(Clk), .Rest(Rest),
    .InitDone(InitDone), .InitCmd(InitCmd), .InitAddr(InitAddr), .InitBa(InitBa),
    .ArefReq(ArefReq), .ArefCmd(ArefCmd), .ArefMode(ArefMode), .ArefDone(ArefDone),
    .ArefStart(ArefStart),
    .WrReq(WrReq), .WrGrant(WrGrant), .WrCmd(WrCmd), .WrAddr(WrAddr), .WrBa(WrBa),
    .WrDone(WrDone),
    .RdReq(RdReq), .RdGrant(RdGrant), .RdCmd(RdCmd), .RdAddr(RdAddr), .RdBa(RdBa),
    .RdDone(RdDone),
    .SdramCmd(SdramCmd), .SdramAddr(SdramAddr), .SdramBa(SdramBa), .ArefMiss(ArefMiss)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rest = 1'b0; InitDone = 1'b0; InitCmd = NOPC; InitAddr = 13'h0000; InitBa = 2'd0;
    ArefReq = 1'b0; ArefCmd = NOPC; ArefMode = 11'h000; ArefDone = 1'b0;
    WrReq = 1'b0; WrCmd = NOPC; WrAddr = 13'h0000; WrBa = 2'd0; WrDone = 1'b0;
    RdReq = 1'b0; RdCmd = NOPC; RdAddr = 13'h0000; RdBa = 2'd0; RdDone = 1'b0;
    repeat (3) tick();
    n_cmp++; if (SdramCmd !== 4'b0111) begin n_err++; $display("FAIL rst_cmd: got %b want 0111", SdramCmd); end
    n_cmp++; if (SdramAddr !== 13'h0000) begin n_err++; $display("FAIL rst_addr: got %h want 0000", SdramAddr); end
    n_cmp++; if (SdramBa !== 2'd0) begin n_err++; $display("FAIL rst_ba: got %0d want 0", SdramBa); end
    n_cmp++; if ({WrGrant, RdGrant, ArefStart, ArefMiss} !== 4'b0000) begin n_err++; $display("FAIL rst_flags: got %b want 0000", {WrGrant, RdGrant, ArefStart, ArefMiss}); end
    Rest = 1'b1;
  endtask

  task automatic test_init();
    InitCmd = PRECHAGE; InitAddr = 13'h0400; InitBa = 2'd1; WrReq = 1'b1;
    tick();
    n_cmp++; if (SdramCmd !== PRECHAGE) begin n_err++; $display("FAIL init_cmd: got %b want %b", SdramCmd, PRECHAGE); end
    n_cmp++; if (SdramAddr !== 13'h0400) begin n_err++; $display("FAIL init_addr: got %h want 0400", SdramAddr); end
    n_cmp++; if (SdramBa !== 2'd1) begin n_err++; $display("FAIL init_ba: got %0d want 1", SdramBa); end
    repeat (3) tick();
    n_cmp++; if (WrGrant !== 1'b0) begin n_err++; $display("FAIL init_ignores_wr: got %b want 0", WrGrant); end
    InitDone = 1'b1; InitCmd = ACTIVE;
    tick();
    n_cmp++; if (SdramCmd !== ACTIVE) begin n_err++; $display("FAIL init_last_cmd: got %b want %b", SdramCmd, ACTIVE); end
    n_cmp++; if (WrGrant !== 1'b0) begin n_err++; $display("FAIL init_exit_grant: got %b want 0", WrGrant); end
    WrReq = 1'b0; InitCmd = PRECHAGE;
    repeat (2) begin
      tick();
      n_cmp++; if (SdramCmd !== NOPC || SdramAddr !== 13'h0000) begin n_err++; $display("FAIL idle_pins: got %b/%h want 0111/0000", SdramCmd, SdramAddr); end
    end
  endtask

  task automatic test_aref();
    ArefReq = 1'b1;
    tick();
    n_cmp++; if (ArefStart !== 1'b1) begin n_err++; $display("FAIL aref_start_hi: got %b want 1", ArefStart); end
    n_cmp++; if (SdramCmd !== NOPC) begin n_err++; $display("FAIL aref_idle_cmd: got %b want 0111", SdramCmd); end
    ArefReq = 1'b0; ArefCmd = PRECHAGE; ArefMode = 11'h400;
    tick();
    n_cmp++; if (ArefStart !== 1'b0) begin n_err++; $display("FAIL aref_start_lo: got %b want 0", ArefStart); end
    n_cmp++; if (SdramCmd !== PRECHAGE || SdramAddr !== 13'h0400 || SdramBa !== 2'd0) begin n_err++; $display("FAIL aref_pre: got %b/%h/%0d want 0010/0400/0", SdramCmd, SdramAddr, SdramBa); end
    ArefCmd = AUTOREF; ArefMode = 11'h000;
    tick();
    n_cmp++; if (SdramCmd !== AUTOREF || SdramAddr !== 13'h0000) begin n_err++; $display("FAIL aref_ref: got %b/%h want 0001/0000", SdramCmd, SdramAddr); end
    n_cmp++; if (ArefMiss !== 1'b0) begin n_err++; $display("FAIL aref_no_miss: got %b want 0", ArefMiss); end
    ArefCmd = NOPC; ArefDone = 1'b1;
    tick();
    ArefDone = 1'b0;
    tick();
    n_cmp++; if (SdramCmd !== NOPC || ArefStart !== 1'b0) begin n_err++; $display("FAIL aref_back_idle: got %b/%b want 0111/0", SdramCmd, ArefStart); end
  endtask

  task automatic test_alternate();
    logic is_rd;
    WrReq = 1'b1; RdReq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      is_rd = (i % 2 == 1);
      tick();
      n_cmp++; if ({WrGrant, RdGrant} !== (is_rd ? 2'b01 : 2'b10)) begin n_err++; $display("FAIL alt_grant%0d: got %b want %b", i, {WrGrant, RdGrant}, (is_rd ? 2'b01 : 2'b10)); end
      n_cmp++; if (SdramCmd !== NOPC) begin n_err++; $display("FAIL alt_idle_cmd%0d: got %b want 0111", i, SdramCmd); end
      if (is_rd) RdReq = 1'b0; else WrReq = 1'b0;
      WrCmd = WRITE; RdCmd = READ;
      for (int c = 1; c < 8; c++) begin
        tick();
        n_cmp++; if ({WrGrant, RdGrant} !== (is_rd ? 2'b01 : 2'b10)) begin n_err++; $display("FAIL alt_hold%0d_%0d: got %b want %b", i, c, {WrGrant, RdGrant}, (is_rd ? 2'b01 : 2'b10)); end
        n_cmp++; if (SdramCmd !== (is_rd ? READ : WRITE)) begin n_err++; $display("FAIL alt_pins%0d_%0d: got %b want %b", i, c, SdramCmd, (is_rd ? READ : WRITE)); end
        if (is_rd) WrDone = (c == 4); else RdDone = (c == 4);
        if (c == 7) begin
          if (is_rd) RdDone = 1'b1; else WrDone = 1'b1;
        end
      end
      tick();
      n_cmp++; if ({WrGrant, RdGrant} !== 2'b00) begin n_err++; $display("FAIL alt_release%0d: got %b want 00", i, {WrGrant, RdGrant}); end
      WrDone = 1'b0; RdDone = 1'b0; WrCmd = NOPC; RdCmd = NOPC;
      if (i < 3) begin
        if (is_rd) RdReq = 1'b1; else WrReq = 1'b1;
      end else begin
        WrReq = 1'b0; RdReq = 1'b0;
      end
    end
    tick();
    n_cmp++; if ({WrGrant, RdGrant} !== 2'b00 || SdramCmd !== NOPC) begin n_err++; $display("FAIL alt_end: got %b/%b want 00/0111", {WrGrant, RdGrant}, SdramCmd); end
  endtask

  task automatic test_aref_miss();
    ArefCmd = AUTOREF;
    tick();
    n_cmp++; if (ArefMiss !== 1'b1) begin n_err++; $display("FAIL miss_set: got %b want 1", ArefMiss); end
    n_cmp++; if (SdramCmd !== NOPC) begin n_err++; $display("FAIL miss_no_override: got %b want 0111", SdramCmd); end
    ArefCmd = NOPC;
    repeat (3) tick();
    n_cmp++; if (ArefMiss !== 1'b1) begin n_err++; $display("FAIL miss_sticky: got %b want 1", ArefMiss); end
  endtask

  task automatic test_aref_midburst();
    WrReq = 1'b1; WrCmd = WRITE;
    tick();
    n_cmp++; if (WrGrant !== 1'b1) begin n_err++; $display("FAIL mb_wgrant: got %b want 1", WrGrant); end
    WrReq = 1'b0;
    for (int c = 1; c < 8; c++) begin
      tick();
      n_cmp++; if ({WrGrant, RdGrant, ArefStart} !== 3'b100) begin n_err++; $display("FAIL mb_burst%0d: got %b want 100", c, {WrGrant, RdGrant, ArefStart}); end
      if (c == 3) begin ArefReq = 1'b1; RdReq = 1'b1; end
      if (c == 7) WrDone = 1'b1;
    end
    tick();
    n_cmp++; if ({WrGrant, RdGrant, ArefStart} !== 3'b000) begin n_err++; $display("FAIL mb_done: got %b want 000", {WrGrant, RdGrant, ArefStart}); end
    WrDone = 1'b0; WrCmd = NOPC;
    tick();
    n_cmp++; if ({WrGrant, RdGrant, ArefStart} !== 3'b001) begin n_err++; $display("FAIL mb_start: got %b want 001", {WrGrant, RdGrant, ArefStart}); end
    ArefReq = 1'b0;
    tick();
    n_cmp++; if ({RdGrant, ArefStart} !== 2'b00) begin n_err++; $display("FAIL mb_in_aref: got %b want 00", {RdGrant, ArefStart}); end
    ArefDone = 1'b1;
    tick();
    ArefDone = 1'b0;
    n_cmp++; if (RdGrant !== 1'b0) begin n_err++; $display("FAIL mb_gap: got %b want 0", RdGrant); end
    tick();
    n_cmp++; if (RdGrant !== 1'b1) begin n_err++; $display("FAIL mb_rgrant: got %b want 1", RdGrant); end
    RdReq = 1'b0; RdCmd = READ; RdAddr = 13'h1abc; RdBa = 2'd3;
    tick();
    n_cmp++; if (SdramCmd !== READ || SdramAddr !== 13'h1abc || SdramBa !== 2'd3) begin n_err++; $display("FAIL mb_rd_pins: got %b/%h/%0d want 0101/1abc/3", SdramCmd, SdramAddr, SdramBa); end
  endtask

  task automatic test_reset_midread();
    #3;
    Rest = 1'b0;
    #1;
    n_cmp++; if (RdGrant !== 1'b0 || SdramCmd !== 4'b0111) begin n_err++; $display("FAIL async_rst: got %b/%b want 0/0111", RdGrant, SdramCmd); end
    n_cmp++; if (ArefMiss !== 1'b0) begin n_err++; $display("FAIL async_rst_miss: got %b want 0", ArefMiss); end
    InitDone = 1'b0; InitCmd = ACTIVE; RdReq = 1'b1; RdCmd = NOPC;
    tick();
    Rest = 1'b1;
    tick();
    n_cmp++; if (SdramCmd !== ACTIVE || RdGrant !== 1'b0) begin n_err++; $display("FAIL post_rst_init: got %b/%b want 0011/0", SdramCmd, RdGrant); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_aref();
    test_alternate();
    test_aref_miss();
    test_aref_midburst();
    test_reset_midread();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sdram_cmd_arbiter
